// File: rtl/iq_demod_pkg.sv
// Shared definitions for the IQ demodulator: FSM encodings, default widths,
// and the accumulator width derivation.
package iq_demod_pkg;

  localparam int DEF_N        = 14;
  localparam int DEF_M        = 14;
  localparam int DEF_WIN_LOG2 = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Full-precision product (n+m) plus w guard bits for 2^w summands.
  function automatic int acc_width(input int n, input int m, input int w);
    return n + m + w;
  endfunction

endpackage

// File: rtl/iq_mac_lane.sv
// One multiply-accumulate lane: registered product with first/last tags,
// tagged accumulator, and a held output register with a one-cycle strobe.
module iq_mac_lane #(
  parameter int N     = 14,
  parameter int M     = 14,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [N-1:0]     sample,
  input  logic signed [M-1:0]     ref_in,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic signed [ACC_W-1:0] sum_out,
  output logic                    sum_valid
);

  logic signed [N+M-1:0]   prod;
  logic                    prod_valid;
  logic                    prod_first;
  logic                    prod_last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_next;

  // Product stage: full-precision multiply of each accepted sample, tags travel alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      prod_first <= in_valid & in_first;
      prod_last  <= in_valid & in_last;
      if (in_valid) prod <= sample * ref_in;
    end
  end

  // A first-tagged product restarts the sum so no residue from an older window survives.
  always_comb begin
    prod_ext = ACC_W'(prod);
    sum_next = prod_first ? prod_ext : (acc + prod_ext);
  end

  // Accumulate valid products; a last-tagged product publishes the finished sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (prod_valid) begin
        acc <= sum_next;
        if (prod_last) begin
          sum_out   <= sum_next;
          sum_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iq_window_accumulator.sv
// I/Q mixing and boxcar integration over 2^WIN_LOG2 accepted samples.
// Optional build macro: IQ_ACC_FREE_RUN_EN (free-running back-to-back windows,
// start ignored). Without it each start runs exactly one window.
// Handshake: a sample is accepted on a rising edge where the FSM is in RUN and
// sample_valid=1; there is no backpressure. out_valid is a one-cycle strobe with
// i_out/q_out held until the next window completes.
module iq_window_accumulator
  import iq_demod_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int ACC_W    = acc_width(N, M, WIN_LOG2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [N-1:0]     sample_in,
  input  logic                    sample_valid,
  input  logic signed [M-1:0]     ref_cos,
  input  logic signed [M-1:0]     ref_sin,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic                    out_valid,
  output logic                    busy
);

  state_t              state, state_next;
  logic [WIN_LOG2-1:0] cnt, cnt_next;
  logic                accept;
  logic                tag_first;
  logic                tag_last;
  logic                q_valid_unused;

  assign accept    = (state == ST_RUN) && sample_valid;
  assign tag_first = (cnt == '0);
  assign tag_last  = (cnt == {WIN_LOG2{1'b1}});
  assign busy      = (state != ST_IDLE);

  // State and window counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: the counter only advances on accepted samples, so gaps just stall it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
`ifdef IQ_ACC_FREE_RUN_EN
        state_next = ST_RUN;
        cnt_next   = '0;
`else
        if (start) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
`endif
      end
      ST_RUN: begin
        if (accept) begin
          // The counter wraps naturally, so in free-run the next sample is tagged first.
          cnt_next = cnt + 1'b1;
`ifndef IQ_ACC_FREE_RUN_EN
          if (tag_last) state_next = ST_DRAIN;
`endif
        end
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  iq_mac_lane #(.N(N), .M(M), .ACC_W(ACC_W)) u_lane_i (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample_in),
    .ref_in    (ref_cos),
    .in_valid  (accept),
    .in_first  (tag_first),
    .in_last   (tag_last),
    .sum_out   (i_out),
    .sum_valid (out_valid)
  );

  // Both lanes see identical tags, so the Q strobe duplicates the I strobe.
  iq_mac_lane #(.N(N), .M(M), .ACC_W(ACC_W)) u_lane_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample_in),
    .ref_in    (ref_sin),
    .in_valid  (accept),
    .in_first  (tag_first),
    .in_last   (tag_last),
    .sum_out   (q_out),
    .sum_valid (q_valid_unused)
  );

endmodule

// File: tb/tb_iq_window_accumulator.sv
// Self-checking bench for iq_window_accumulator with a 4-sample window.
// M is widened to 15 so that a +8192 cosine reference is representable.
module tb_iq_window_accumulator;

  localparam int N     = 14;
  localparam int M     = 15;
  localparam int W     = 2;
  localparam int ACC_W = N + M + W;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic signed [N-1:0]     sample_in;
  logic                    sample_valid;
  logic signed [M-1:0]     ref_cos;
  logic signed [M-1:0]     ref_sin;
  logic signed [ACC_W-1:0] i_out;
  logic signed [ACC_W-1:0] q_out;
  logic                    out_valid;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  logic [ACC_W-1:0] exp_i_q[$];
  logic [ACC_W-1:0] exp_q_q[$];

  iq_window_accumulator #(.N(N), .M(M), .WIN_LOG2(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ref_cos      (ref_cos),
    .ref_sin      (ref_sin),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [ACC_W-1:0] ei, eq;
    if (rst_n && out_valid) begin
      if (exp_i_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_strobe: out_valid=1 with i_out=%0d q_out=%0d, no window expected at %0t",
                 i_out, q_out, $time);
      end else begin
        ei = exp_i_q.pop_front();
        eq = exp_q_q.pop_front();
        tests++;
        if (i_out !== ei) begin
          fails++;
          $display("FAIL i_out: got %0d expected %0d", i_out, $signed(ei));
        end
        tests++;
        if (q_out !== eq) begin
          fails++;
          $display("FAIL q_out: got %0d expected %0d", q_out, $signed(eq));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives inputs for the next rising edge and returns at the following negedge.
  task automatic cyc(input logic st, input logic v, input logic signed [N-1:0] s,
                     input logic signed [M-1:0] c, input logic signed [M-1:0] sn);
    start        = st;
    sample_valid = v;
    sample_in    = s;
    ref_cos      = c;
    ref_sin      = sn;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic push_exp(input logic signed [ACC_W-1:0] ei, input logic signed [ACC_W-1:0] eq);
    exp_i_q.push_back(ei);
    exp_q_q.push_back(eq);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; sample_valid = 1'b0; sample_in = '0; ref_cos = '0; ref_sin = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; sample_valid = 1'b0; sample_in = '0; ref_cos = '0; ref_sin = '0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (i_out !== '0) begin fails++; $display("FAIL reset_i_out: got %0d expected 0", i_out); end
    tests++; if (q_out !== '0) begin fails++; $display("FAIL reset_q_out: got %0d expected 0", q_out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
  endtask

`ifndef IQ_ACC_FREE_RUN_EN
  task automatic test_basic();
    cyc(1'b1, 1'b0, '0, '0, '0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_exp(3276800, 0);
      cyc(1'b0, 1'b1, 100, 8192, 0);
    end
    // Just after the last acceptance edge: product stage loaded, no strobe yet, DRAIN.
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_strobe: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_drain: got %b expected 1", busy); end
    idle(1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_strobe: got %b expected 1", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    idle(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_strobe_width: got %b expected 0", out_valid); end
    tests++; if (i_out !== 31'sd3276800) begin fails++; $display("FAIL basic_hold: got %0d expected 3276800", i_out); end
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL basic_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask

  task automatic test_negative();
    cyc(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_exp(268402688, -268369924);
      cyc(1'b0, 1'b1, -8191, -8192, 8191);
    end
    idle(3);
    tests++; if (q_out !== -31'sd268369924) begin fails++; $display("FAIL neg_q_hold: got %0d expected -268369924", q_out); end
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL neg_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    int nv;
    pat = 7'b1101001; // LSB first: 1,0,0,1,0,1,1
    nv  = 0;
    cyc(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 7; k++) begin
      if (pat[k]) begin
        nv++;
        if (nv == 4) push_exp(4, 0);
      end
      cyc(1'b0, pat[k], 1, 1, 0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL gaps_busy[%0d]: got %b expected 1", k, busy); end
    end
    idle(2);
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL gaps_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 7, 7, 7);
    cyc(1'b0, 1'b1, 7, 7, 7);
    rst_n = 1'b0;
    start = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    tests++; if (i_out !== '0) begin fails++; $display("FAIL midreset_i_out: got %0d expected 0", i_out); end
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_exp(4, 0);
      cyc(1'b0, 1'b1, 1, 1, 0);
    end
    idle(2);
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL midreset_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask

  task automatic test_start_ignored();
    // Start coincident with a valid sample in IDLE: that sample must not count.
    cyc(1'b1, 1'b1, 1000, 1, 2);
    cyc(1'b1, 1'b1, 2, 1, 2);   // start during RUN: ignored
    cyc(1'b0, 1'b1, 3, 1, 2);
    cyc(1'b1, 1'b1, 4, 1, 2);
    push_exp(14, 28);
    cyc(1'b0, 1'b1, 5, 1, 2);
    cyc(1'b1, 1'b0, '0, '0, '0); // start sampled in DRAIN: ignored
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_drain_busy: got %b expected 0", busy); end
    idle(1);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_drain_stays_idle: got %b expected 0", busy); end
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL start_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic signed [N-1:0]     s;
    logic signed [M-1:0]     c, sn;
    logic signed [ACC_W-1:0] ai, aq;
    logic                    v;
    int                      nv;
    for (int w = 0; w < 3; w++) begin
      cyc(1'b1, 1'b0, '0, '0, '0);
      ai = '0; aq = '0; nv = 0;
      while (nv < 4) begin
        v  = ($urandom_range(0, 3) != 0);
        s  = N'($urandom_range(0, (1 << N) - 1));
        c  = M'($urandom_range(0, (1 << M) - 1));
        sn = M'($urandom_range(0, (1 << M) - 1));
        if (v) begin
          ai = ai + s * c;
          aq = aq + s * sn;
          nv++;
          if (nv == 4) push_exp(ai, aq);
        end
        cyc(1'b0, v, s, c, sn);
      end
      idle(1); // DRAIN edge; next start lands at the minimum spacing
    end
    idle(2);
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL b2b_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
  endtask
`else
  task automatic test_free_run();
    logic signed [ACC_W-1:0] ai;
    idle(1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL free_busy: got %b expected 1", busy); end
    ai = '0;
    for (int k = 1; k <= 12; k++) begin
      ai = ai + k;
      if (k % 4 == 0) begin
        push_exp(ai, 0);
        ai = '0;
      end
      cyc(1'b0, 1'b1, N'(k), 1, 0);
    end
    idle(3);
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL free_missing_strobe: pending %0d expected 0", exp_i_q.size()); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL free_busy_end: got %b expected 1", busy); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    @(negedge clk);
`ifndef IQ_ACC_FREE_RUN_EN
    test_basic();
    test_negative();
    test_gaps();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
`else
    test_free_run();
`endif
    do_reset();
    idle(2);
    tests++; if (exp_i_q.size() != 0) begin fails++; $display("FAIL final_queue: pending %0d expected 0", exp_i_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
